argmax_top2_scan: RTL and testbench

- Parametrised successor to the classifier-output max selector.
- Snapshots N_IN signed scores from the final layer and scans them at LANES elements per cycle.
- Reports the argmax index, the max value, the runner-up value, and the max-minus-runner-up confidence margin.
- Signals completion with layer_done, which downstream digit-display and control logic consume.

---
 rtl/argmax_top2_scan.sv | 177 +++++++++++++++++
 tb/tb_argmax_top2_scan.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_top2_scan.sv
`default_nettype none
// argmax_top2_scan: snapshots N_IN signed scores, scans LANES per clock, reports argmax, runner-up and margin.
// Rev 1.0
module argmax_top2_scan #(
  parameter int N_IN   = 10,
  parameter int DATA_W = 16,
  parameter int LANES  = 1,
  parameter int IDX_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [N_IN-1:0][DATA_W-1:0] in_data,
  output logic [IDX_W-1:0]            digit,
  output logic signed [DATA_W-1:0]    max,
  output logic signed [DATA_W-1:0]    second,
  output logic [DATA_W:0]             margin,
  output logic                        busy,
  output logic                        layer_done
);

  localparam int CNT_W = $clog2(N_IN + LANES + 1);
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                     state_q, state_d;
  logic signed [DATA_W-1:0]   snap_q [N_IN];
  logic signed [DATA_W-1:0]   snap_d [N_IN];
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [DATA_W-1:0]   best_q, best_d;
  logic signed [DATA_W-1:0]   sbest_q, sbest_d;
  logic [IDX_W-1:0]           best_idx_q, best_idx_d;
  logic [IDX_W-1:0]           digit_q, digit_d;
  logic signed [DATA_W-1:0]   max_q, max_d;
  logic signed [DATA_W-1:0]   second_q, second_d;
  logic [DATA_W:0]            margin_q, margin_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic signed [DATA_W-1:0]   chain_best, chain_second, lane_x;
  logic [IDX_W-1:0]           chain_idx;
  logic [CNT_W-1:0]           lane_idx;
  logic                       lane_ok;
  logic                       last_scan;

  // Lanes are folded in ascending index order so any LANES matches the one-lane result.
  always_comb begin
    chain_best   = best_q;
    chain_second = sbest_q;
    chain_idx    = best_idx_q;
    lane_idx     = '0;
    lane_x       = MOST_NEG;
    lane_ok      = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx = cnt_q + CNT_W'(l);
      lane_x   = MOST_NEG;
      lane_ok  = 1'b0;
      for (int j = 0; j < N_IN; j++) begin
        if (lane_idx == CNT_W'(j)) begin
          lane_x  = snap_q[j];
          lane_ok = 1'b1;
        end
      end
      if (lane_ok) begin
        if (lane_x > chain_best) begin
          chain_second = chain_best;
          chain_best   = lane_x;
          chain_idx    = IDX_W'(lane_idx);
        end else if (lane_x > chain_second) begin
          chain_second = lane_x;
        end
      end
    end
  end

  assign last_scan = (cnt_q + CNT_W'(LANES)) >= CNT_W'(N_IN);

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    cnt_d      = cnt_q;
    best_d     = best_q;
    sbest_d    = sbest_q;
    best_idx_d = best_idx_q;
    digit_d    = digit_q;
    max_d      = max_q;
    second_d   = second_q;
    margin_d   = margin_q;
    busy_d     = busy_q;
    done_d     = done_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          for (int j = 0; j < N_IN; j++) snap_d[j] = in_data[j];
          best_d     = MOST_NEG;
          sbest_d    = MOST_NEG;
          best_idx_d = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!enable) begin
          // Abort: partial result is dropped, published outputs keep the last completed scan.
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          best_d     = chain_best;
          sbest_d    = chain_second;
          best_idx_d = chain_idx;
          cnt_d      = cnt_q + CNT_W'(LANES);
          if (last_scan) begin
            digit_d  = chain_idx;
            max_d    = chain_best;
            second_d = chain_second;
            margin_d = {chain_best[DATA_W-1], chain_best} - {chain_second[DATA_W-1], chain_second};
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!enable) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      for (int j = 0; j < N_IN; j++) snap_q[j] <= '0;
      cnt_q      <= '0;
      best_q     <= '0;
      sbest_q    <= '0;
      best_idx_q <= '0;
      digit_q    <= '0;
      max_q      <= '0;
      second_q   <= '0;
      margin_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      cnt_q      <= cnt_d;
      best_q     <= best_d;
      sbest_q    <= sbest_d;
      best_idx_q <= best_idx_d;
      digit_q    <= digit_d;
      max_q      <= max_d;
      second_q   <= second_d;
      margin_q   <= margin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign digit      = digit_q;
  assign max        = max_q;
  assign second     = second_q;
  assign margin     = margin_q;
  assign busy       = busy_q;
  assign layer_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_argmax_top2_scan.sv
`default_nettype none
// tb_argmax_top2_scan: four instances (LANES 1,3,4,10) share stimulus; results checked against a top-2 model.
// Rev 1.0
module tb_argmax_top2_scan;

  typedef logic [9:0][15:0] vec_t;

  function automatic int lanes_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 10;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  vec_t        in_data = '0;

  logic [7:0]  digit_w  [4];
  logic [15:0] max_w    [4];
  logic [15:0] second_w [4];
  logic [16:0] margin_w [4];
  logic        busy_w   [4];
  logic        done_w   [4];

  logic [7:0]  od [4];
  logic [15:0] om [4];
  logic [15:0] os [4];
  logic [16:0] og [4];

  int total = 0;
  int bad   = 0;

  int dv [6][10] = '{
    '{0, 0, 5, 85, 0, 10, 0, 0, 0, 0},
    '{7, -3, 7, 1, 0, 0, 0, 0, 0, 0},
    '{-5, -2, -9, -100, -100, -100, -100, -100, -100, -100},
    '{32767, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768},
    '{1, 2, 3, 4, 5, 6, 7, 8, 9, 300},
    '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1}
  };

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    argmax_top2_scan #(.N_IN(10), .DATA_W(16), .LANES(lanes_of(g)), .IDX_W(8)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .in_data    (in_data),
      .digit      (digit_w[g]),
      .max        (max_w[g]),
      .second     (second_w[g]),
      .margin     (margin_w[g]),
      .busy       (busy_w[g]),
      .layer_done (done_w[g])
    );
  end

  // Top-2 by definition: first strictly-largest element, then the largest of all the others.
  function automatic void ref_top2(input vec_t v, output logic [7:0] di,
                                   output logic [15:0] mx, output logic [15:0] sc);
    int bi;
    bit have;
    bi = 0;
    for (int i = 1; i < 10; i++) if ($signed(v[i]) > $signed(v[bi])) bi = i;
    have = 1'b0;
    sc = '0;
    for (int i = 0; i < 10; i++) begin
      if (i != bi && (!have || $signed(v[i]) > $signed(sc))) begin
        sc = v[i];
        have = 1'b1;
      end
    end
    di = 8'(bi);
    mx = v[bi];
  endfunction

  function automatic vec_t table_vec(input int n);
    vec_t v;
    for (int i = 0; i < 10; i++) v[i] = 16'(dv[n][i]);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int mode;
    logic [15:0] same;
    mode = $urandom_range(0, 2);
    same = 16'($urandom);
    for (int i = 0; i < 10; i++) begin
      if (mode == 0)      v[i] = 16'($urandom);
      else if (mode == 1) v[i] = 16'($urandom_range(0, 6)) - 16'd3;
      else                v[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : same;
    end
    return v;
  endfunction

  // Enable is dropped so that it is low at the abort_c-th edge after the start edge.
  task automatic run_scan(input vec_t v, input int abort_c, input string tag);
    logic [7:0]  nd;
    logic [15:0] nm, ns;
    logic [16:0] ng;
    logic [1:0]  got_c, exp_c;
    logic [56:0] got_r, exp_r;
    int k;
    bit fin;
    ref_top2(v, nd, nm, ns);
    ng = 17'(int'($signed(nm)) - int'($signed(ns)));
    in_data = v;
    enable  = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= abort_c; c++) begin
      for (int d = 0; d < 4; d++) begin
        k = (10 + lanes_of(d) - 1) / lanes_of(d);
        if (c < abort_c) begin
          exp_c = {c < k, c >= k};
          fin   = (c >= k);
        end else begin
          exp_c = 2'b00;
          fin   = (k < c);
        end
        exp_r = fin ? {nd, nm, ns, ng} : {od[d], om[d], os[d], og[d]};
        got_c = {busy_w[d], done_w[d]};
        got_r = {digit_w[d], max_w[d], second_w[d], margin_w[d]};
        total++;
        if (got_c !== exp_c) begin
          bad++;
          $display("FAIL %s ctrl L=%0d c=%0d busy,done got=%b want=%b", tag, lanes_of(d), c, got_c, exp_c);
        end
        total++;
        if (got_r !== exp_r) begin
          bad++;
          $display("FAIL %s result L=%0d c=%0d digit/max/second/margin got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
                   tag, lanes_of(d), c, got_r[56:49], $signed(got_r[48:33]), $signed(got_r[32:17]), got_r[16:0],
                   exp_r[56:49], $signed(exp_r[48:33]), $signed(exp_r[32:17]), exp_r[16:0]);
        end
      end
      if (c == 1 || c == 10) for (int i = 0; i < 10; i++) in_data[i] = 16'($urandom);
      if (c == abort_c - 1) enable = 1'b0;
      if (c < abort_c) begin
        @(posedge clk); #1;
      end
    end
    for (int d = 0; d < 4; d++) begin
      k = (10 + lanes_of(d) - 1) / lanes_of(d);
      if (k < abort_c) begin
        od[d] = nd; om[d] = nm; os[d] = ns; og[d] = ng;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 4; d++) begin
      total++;
      if ({busy_w[d], done_w[d], digit_w[d], max_w[d], second_w[d], margin_w[d]} !== 59'd0) begin
        bad++;
        $display("FAIL %s L=%0d outputs got busy=%b done=%b digit=%0d max=%0d second=%0d margin=%0d want all 0",
                 tag, lanes_of(d), busy_w[d], done_w[d], digit_w[d], max_w[d], second_w[d], margin_w[d]);
      end
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 4; d++) begin
      od[d] = '0; om[d] = '0; os[d] = '0; og[d] = '0;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1 check_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_held");
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset_released");
    clear_model();
  endtask

  task automatic test_directed();
    for (int n = 0; n < 6; n++) run_scan(table_vec(n), 12, $sformatf("directed%0d", n));
  endtask

  task automatic test_abort();
    run_scan(table_vec(0), 5, "abort_e5");
    run_scan(table_vec(4), 12, "after_abort_idx9");
    run_scan(table_vec(1), 1, "abort_e1");
    run_scan(rand_vec(), 10, "abort_e10");
  endtask

  task automatic test_random();
    int ac;
    for (int n = 0; n < 24; n++) begin
      ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : 12;
      run_scan(rand_vec(), ac, $sformatf("random%0d", n));
    end
  endtask

  task automatic test_reset_mid();
    in_data = table_vec(2);
    enable  = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1 check_all_zero("reset_mid_scan");
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    clear_model();
    run_scan(table_vec(0), 12, "after_reset");
    run_scan(table_vec(3), 12, "after_reset_extreme");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
